axi4lite_reg_sub: RTL and testbench

AXI4-Lite subordinate register bank. It is the 4-word control/status target that sits directly behind the interconnect's AXI4-Lite manager port, and it is the DUT that the team's AXI4-Lite assertion checker binds to. Write and read channels are independent, and each channel runs strictly ordered handshakes:
- write: AW, then W, then B;
- read: AR, then R.

Responses are OKAY or SLVERR only.

---
 rtl/axi4lite_reg_sub.sv | 211 +++++++++++++++++++++
 tb/tb_axi4lite_reg_sub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_reg_sub.sv
// AXI4-Lite subordinate with a 4-word control/status bank (CTRL, SCRATCH, STATUS, ID).
// Write and read channels run independent, strictly ordered handshake FSMs with registered outputs.
//
// state  | meaning
// W_ADDR | waiting for AW handshake (AWREADY high once out of reset)
// W_DATA | address captured, waiting for W handshake (WREADY high)
// W_RESP | response loaded, BVALID high until BREADY
// R_ADDR | waiting for AR handshake (ARREADY high once out of reset)
// R_DATA | read data loaded, RVALID high until RREADY
module axi4lite_reg_sub #(
  parameter logic [31:0] ID_VALUE   = 32'hA41C_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_SCRATCH = 2'd1;
  localparam logic [1:0] IDX_STATUS  = 2'd2;

  w_state_t    w_state;
  r_state_t    r_state;

  logic [1:0]  wr_idx;
  logic        wr_priv;

  logic [31:0] ctrl_reg;
  logic [31:0] scratch_reg;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        wr_err;
  logic [31:0] rd_mux;

  logic        unused_sig;
  assign unused_sig = ^{S_AXI_AWADDR[1:0], S_AXI_AWPROT[2:1], S_AXI_ARADDR[1:0], S_AXI_ARPROT};

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  assign aw_hs = (w_state == W_ADDR) && S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = (r_state == R_ADDR) && S_AXI_ARVALID && S_AXI_ARREADY;

  // STATUS and ID are read-only; CTRL additionally requires a privileged access.
  always_comb begin
    wr_err = 1'b0;
    case (wr_idx)
      IDX_CTRL:    wr_err = !wr_priv;
      IDX_SCRATCH: wr_err = 1'b0;
      default:     wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      IDX_CTRL:    rd_mux = ctrl_reg;
      IDX_SCRATCH: rd_mux = scratch_reg;
      IDX_STATUS:  rd_mux = {err_count, ok_count};
      default:     rd_mux = ID_VALUE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state       <= W_ADDR;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      wr_idx        <= 2'd0;
      wr_priv       <= 1'b0;
    end else begin
      case (w_state)
        W_ADDR: begin
          if (aw_hs) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            wr_idx        <= S_AXI_AWADDR[3:2];
            wr_priv       <= S_AXI_AWPROT[0];
            w_state       <= W_DATA;
          end else begin
            S_AXI_AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_ADDR;
          end
        end
        default: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b0;
          w_state       <= W_ADDR;
        end
      endcase
    end
  end

  // Register commit happens on the W handshake edge, so a read sampled on
  // that same edge still sees the old contents.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ctrl_reg    <= CTRL_RESET;
      scratch_reg <= 32'h0;
      ok_count    <= 16'h0;
      err_count   <= 16'h0;
    end else if (w_hs) begin
      if (wr_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else begin
        ok_count <= ok_count + 16'd1;
        case (wr_idx)
          IDX_CTRL:    ctrl_reg    <= apply_strb(ctrl_reg, S_AXI_WDATA, S_AXI_WSTRB);
          IDX_SCRATCH: scratch_reg <= apply_strb(scratch_reg, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state       <= R_ADDR;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= 32'h0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_ADDR: begin
          if (ar_hs) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_mux;
            S_AXI_RRESP   <= RESP_OKAY;
            r_state       <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= 32'h0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_ADDR;
          end
        end
        default: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_RDATA   <= 32'h0;
          r_state       <= R_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_sub.sv
// Directed bench for axi4lite_reg_sub: a small register model feeds expected
// BRESP/RDATA into queues that are popped when the DUT responds.
module tb_axi4lite_reg_sub;

  localparam logic [31:0] ID_VALUE   = 32'hA41C_0001;
  localparam logic [31:0] CTRL_RESET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  logic [31:0] ctrl_m, scratch_m;
  logic [15:0] ok_m, err_m;
  logic [1:0]  bresp_q[$];
  logic [31:0] rdata_q[$];

  axi4lite_reg_sub #(.ID_VALUE(ID_VALUE), .CTRL_RESET(CTRL_RESET)) dut (
    .S_AXI_ACLK(clk),        .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),   .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),     .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),   .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ctrl_m    = CTRL_RESET;
    scratch_m = 32'h0;
    ok_m      = 16'h0;
    err_m     = 16'h0;
  endtask

  task automatic model_write(input logic [1:0] idx, input logic priv, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    logic ok;
    case (idx)
      2'd0:    ok = priv;
      2'd1:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (ok) begin
      ok_m = ok_m + 16'd1;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          if (idx == 2'd0) ctrl_m[8*b +: 8] = data[8*b +: 8];
          else             scratch_m[8*b +: 8] = data[8*b +: 8];
        end
      end
      resp = 2'b00;
    end else begin
      if (err_m != 16'hFFFF) err_m = err_m + 16'd1;
      resp = 2'b10;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return ctrl_m;
      2'd1:    return scratch_m;
      2'd2:    return {err_m, ok_m};
      default: return ID_VALUE;
    endcase
  endfunction

  task automatic outputs_zero(input string tag);
    chk(tag, {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp}, 64'h0);
  endtask

  task automatic aw_handshake(input logic [3:0] addr, input logic [2:0] prot);
    int n;
    awaddr = addr; awprot = prot; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("awready_wait", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    chk("wready_after_aw", {wready, awready}, 2'b10);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [2:0] prot, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, input bit early);
    logic [1:0] er;
    logic [1:0] exp_resp;
    model_write(addr[3:2], prot[0], data, strb, er);
    bresp_q.push_back(er);
    wdata = data; wstrb = strb;
    if (early) begin
      wvalid = 1'b1;
      chk("no_w_in_addr", wready, 1'b0);
    end
    aw_handshake(addr, prot);
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("bvalid_after_w", {bvalid, wready, awready}, 3'b100);
    exp_resp = bresp_q.pop_front();
    chk("bresp", bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("b_hold", {bvalid, bresp, awready}, {1'b1, exp_resp, 1'b0});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold);
    int n;
    logic [31:0] exp;
    rdata_q.push_back(model_read(addr[3:2]));
    araddr = addr; arprot = 3'b000; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("arready_wait", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    exp = rdata_q.pop_front();
    chk("rvalid_after_ar", {rvalid, arready}, 2'b10);
    chk("rdata", rdata, exp);
    chk("rresp", rresp, 2'b00);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("r_hold", {rvalid, rdata, rresp}, {1'b1, exp, 2'b00});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("r_done", {rvalid, arready, rdata, rresp}, {2'b01, 32'h0, 2'b00});
  endtask

  initial begin
    logic [1:0]  er;
    logic [31:0] exp_rd;
    logic [1:0]  exp_b;

    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();

    repeat (3) tick();
    outputs_zero("reset_outputs");
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {awready, arready, wready, bvalid, rvalid}, 5'b11000);

    do_write(4'h4, 3'b000, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0);
    do_read(4'h4, 0);

    do_write(4'h0, 3'b000, 32'h1111_1111, 4'b1111, 0, 1'b0);
    do_read(4'h0, 0);
    do_write(4'h0, 3'b001, 32'h0000_AB00, 4'b0010, 0, 1'b0);
    do_read(4'h0, 0);
    do_read(4'h8, 0);

    do_write(4'hC, 3'b001, 32'h5555_5555, 4'b1111, 5, 1'b0);
    do_read(4'hC, 0);
    do_write(4'h8, 3'b001, 32'h5555_5555, 4'b1111, 0, 1'b0);

    do_write(4'h5, 3'b110, 32'h1122_3344, 4'b0101, 0, 1'b1);
    do_write(4'h6, 3'b000, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
    do_read(4'h7, 0);
    do_read(4'h8, 4);

    // Read of CTRL sampled on the same edge as a CTRL write commit.
    exp_rd = model_read(2'd0);
    rdata_q.push_back(exp_rd);
    model_write(2'd0, 1'b1, 32'h1234_5678, 4'b1111, er);
    bresp_q.push_back(er);
    aw_handshake(4'h0, 3'b001);
    wdata = 32'h1234_5678; wstrb = 4'b1111; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1;
    chk("both_ready", {wready, arready}, 2'b11);
    tick();
    wvalid = 1'b0; arvalid = 1'b0;
    chk("both_valid", {bvalid, rvalid}, 2'b11);
    exp_rd = rdata_q.pop_front();
    exp_b  = bresp_q.pop_front();
    chk("rdata_precommit", rdata, exp_rd);
    chk("bresp_concurrent", bresp, exp_b);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("concurrent_done", {bvalid, rvalid, awready, arready}, 4'b0011);
    do_read(4'h0, 0);

    force dut.ok_count = 16'hFFFF;
    tick();
    release dut.ok_count;
    ok_m = 16'hFFFF;
    do_read(4'h8, 0);
    do_write(4'h4, 3'b000, 32'hCAFE_0000, 4'b1100, 0, 1'b0);
    do_read(4'h8, 0);

    force dut.err_count = 16'hFFFE;
    tick();
    release dut.err_count;
    err_m = 16'hFFFE;
    do_write(4'hC, 3'b001, 32'h0, 4'b1111, 0, 1'b0);
    do_write(4'h8, 3'b001, 32'h0, 4'b1111, 0, 1'b0);
    do_write(4'h0, 3'b000, 32'h0, 4'b1111, 0, 1'b0);
    do_read(4'h8, 0);

    // Reset while the write channel sits in W_DATA with WVALID presented.
    aw_handshake(4'h4, 3'b001);
    wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; wvalid = 1'b1;
    rst = 1'b1;
    tick();
    outputs_zero("reset_in_w_data");
    rst = 1'b0; wvalid = 1'b0;
    model_reset();
    tick();
    chk("after_w_reset", {awready, wready, bvalid, arready, rvalid}, 5'b10010);
    do_read(4'h4, 0);
    do_read(4'h0, 0);

    // Reset while the read channel sits in R_DATA.
    araddr = 4'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rvalid_before_reset", rvalid, 1'b1);
    rst = 1'b1;
    tick();
    outputs_zero("reset_in_r_data");
    rst = 1'b0;
    tick();
    chk("after_r_reset", {rvalid, arready, rdata}, {2'b01, 32'h0});
    do_read(4'h8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
